// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and arbiter-state definitions for the ALU arbiter.
// Opcode legality feeds the optional ALU_ARB_OP_CHECK_EN illegal-opcode filter.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_INC  = 4'h4,
    OP_DEC  = 4'h5,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOTA = 4'hB,
    OP_SHL  = 4'hC,
    OP_SHR  = 4'hD,
    OP_PASB = 4'hE
  } alu_op_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR,
      OP_XOR, OP_NOTA, OP_SHL, OP_SHR, OP_PASB: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter_2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && (!valid1_i || last_i)) grant_o = 2'b01;
    else if (valid1_i)                     grant_o = 2'b10;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU (IDLE -> EXEC -> RESP).
// Optional ALU_ARB_OP_CHECK_EN: illegal opcodes return result 0, flags 0 and rsp_err.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req0_op,
  input  logic [3:0]   req1_op,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_s,
  input  logic [N-1:0] alu_z,
  input  logic         alu_carry_out,
  input  logic         alu_msb_sum
);

  arb_state_t   state_q;
  logic         last_q;
  logic         idx_q;
  logic [N-1:0] a_q, b_q;
  logic [3:0]   op_q;
  logic [N-1:0] result_q;
  logic [3:0]   flags_q;
  logic         rsp0_vld_q, rsp1_vld_q;
  logic [1:0]   gnt;
  logic         accept;
  logic         rsp_take;
  logic [3:0]   flags_d;

  rr_arbiter_2 u_rr (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .last_i   (last_q),
    .grant_o  (gnt)
  );

  assign req0_ready = (state_q == ST_IDLE) && gnt[0];
  assign req1_ready = (state_q == ST_IDLE) && gnt[1];
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign rsp_take   = idx_q ? rsp1_ready : rsp0_ready;

  // Carry/overflow only mean something for arithmetic ops (op[3] clear).
  always_comb begin
    flags_d         = 4'b0000;
    flags_d[FLAG_N] = alu_z[N-1];
    flags_d[FLAG_Z] = (alu_z == '0);
    flags_d[FLAG_C] = !op_q[3] && alu_carry_out;
    flags_d[FLAG_V] = !op_q[3] && alu_msb_sum;
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_s      = op_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;
  assign rsp0_valid = rsp0_vld_q;
  assign rsp1_valid = rsp1_vld_q;

`ifdef ALU_ARB_OP_CHECK_EN
  logic err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      idx_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
`ifdef ALU_ARB_OP_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            idx_q   <= gnt[1];
            last_q  <= gnt[1];
            a_q     <= gnt[1] ? req1_a  : req0_a;
            b_q     <= gnt[1] ? req1_b  : req0_b;
            op_q    <= gnt[1] ? req1_op : req0_op;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
`ifdef ALU_ARB_OP_CHECK_EN
          if (!op_is_legal(op_q)) begin
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b1;
          end else begin
            result_q <= alu_z;
            flags_q  <= flags_d;
            err_q    <= 1'b0;
          end
`else
          result_q <= alu_z;
          flags_q  <= flags_d;
`endif
          rsp0_vld_q <= !idx_q;
          rsp1_vld_q <= idx_q;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          // Always return to IDLE so a waiting request is arbitrated a cycle later.
          if (rsp_take) begin
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU; expectations hand-computed.
module tb_alu_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 0, req1_valid = 0;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0]   req0_op = 0, req1_op = 0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 0, rsp1_ready = 0;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_err;
  logic [N-1:0] alu_a, alu_b, alu_z;
  logic [3:0]   alu_s;
  logic         alu_carry_out, alu_msb_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_z(alu_z), .alu_carry_out(alu_carry_out), .alu_msb_sum(alu_msb_sum)
  );

  // Shared ALU: logic ops drive carry/msb high so the arbiter's masking is visible.
  logic [N:0] t;
  always_comb begin
    t = '0;
    alu_z = '0;
    alu_carry_out = 1'b0;
    alu_msb_sum = 1'b0;
    case (alu_s)
      4'h0: begin
        t = {1'b0, alu_a} + {1'b0, alu_b};
        alu_z = t[N-1:0];
        alu_carry_out = t[N];
        alu_msb_sum = (alu_a[N-1] == alu_b[N-1]) && (t[N-1] != alu_a[N-1]);
      end
      4'h1: begin
        t = {1'b0, alu_a} + {1'b0, ~alu_b} + 1;
        alu_z = t[N-1:0];
        alu_carry_out = t[N];
        alu_msb_sum = (alu_a[N-1] != alu_b[N-1]) && (t[N-1] != alu_a[N-1]);
      end
      4'h8: begin
        alu_z = alu_a & alu_b;
        alu_carry_out = 1'b1;
        alu_msb_sum = 1'b1;
      end
      default: alu_z = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input bit k, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [3:0] op, input logic [N-1:0] er,
                        input logic [3:0] ef, input logic ee);
    @(negedge clk);
    if (k) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    else   begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    #1 chk("rdy", {req1_ready, req0_ready}, k ? 2'b10 : 2'b01);
    @(posedge clk); @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1 chk("exec_vld", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("alu_a", alu_a, a);
    chk("alu_s", alu_s, op);
    @(posedge clk); @(negedge clk);
    chk("rsp_vld", {rsp1_valid, rsp0_valid}, k ? 2'b10 : 2'b01);
    chk("result", rsp_result, er);
    chk("flags", rsp_flags, ef);
    chk("err", rsp_err, ee);
    if (k) rsp1_ready = 1; else rsp0_ready = 1;
    @(posedge clk); @(negedge clk);
    chk("done_vld", {rsp1_valid, rsp0_valid}, 2'b00);
    chk("alu_hold", alu_b, b);
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_hs", {req1_ready, req0_ready, rsp1_valid, rsp0_valid}, 4'h0);
    chk("rst_res", rsp_result, 0);
    chk("rst_flg", rsp_flags, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_alu", {alu_a, alu_b, alu_s}, 0);

    // Single request: 5+3
    run_op(0, 32'd5, 32'd3, 4'h0, 32'd8, 4'b0000, 1'b0);
    // Zero result on requester 1: 7-7, carry set (no borrow)
    run_op(1, 32'd7, 32'd7, 4'h1, 32'd0, 4'b0110, 1'b0);

    // Ties from reset: grants at cycles 0,3,6,9 alternate 0,1,0,1
    do_reset();
    @(negedge clk);
    req0_valid = 1; req0_a = 32'd10;  req0_b = 32'd20; req0_op = 4'h0;
    req1_valid = 1; req1_a = 32'd100; req1_b = 32'd1;  req1_op = 4'h1;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 10) begin req0_valid = 0; req1_valid = 0; end
      #1;
      if (c % 3 == 0)
        chk("tie_gnt", {req1_ready, req0_ready}, ((c / 3) % 2) ? 2'b10 : 2'b01);
      else
        chk("tie_busy", {req1_ready, req0_ready}, 2'b00);
      if (c % 3 == 2) begin
        chk("tie_rsp", {rsp1_valid, rsp0_valid}, ((c / 3) % 2) ? 2'b10 : 2'b01);
        chk("tie_res", rsp_result, ((c / 3) % 2) ? 32'd99 : 32'd30);
      end
      @(posedge clk);
    end
    @(negedge clk);
    rsp0_ready = 0; rsp1_ready = 0;

    // Backpressure on requester 0 while requester 1 waits
    req0_valid = 1; req0_a = 32'hF0F0_0000; req0_b = 32'hFF00_0000; req0_op = 4'h8;
    @(posedge clk); @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_op = 4'h0;
    #1 chk("bp_exec_rdy", req1_ready, 1'b0);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", {rsp1_valid, rsp0_valid}, 2'b01);
      chk("bp_res", rsp_result, 32'hF000_0000);
      chk("bp_flg", rsp_flags, 4'b1000);
      chk("bp_rdy1", req1_ready, 1'b0);
    end
    rsp0_ready = 1;
    @(posedge clk); @(negedge clk);
    rsp0_ready = 0;
    #1 chk("bp_idle_rdy1", {req1_ready, req0_ready}, 2'b10);
    @(posedge clk); @(negedge clk);
    req1_valid = 0;
    @(posedge clk); @(negedge clk);
    chk("bp_r1_vld", {rsp1_valid, rsp0_valid}, 2'b10);
    chk("bp_r1_res", rsp_result, 32'h8000_0000);
    chk("bp_r1_flg", rsp_flags, 4'b1001);
    rsp1_ready = 1;
    @(posedge clk); @(negedge clk);
    rsp1_ready = 0;

    // Reset while in EXEC discards the operation
    req0_valid = 1; req0_a = 32'd9; req0_b = 32'd9; req0_op = 4'h0;
    @(posedge clk); @(negedge clk);
    req0_valid = 0;
    rst = 1;
    #1 chk("mid_rst_alu", alu_a, 0);
    chk("mid_rst_vld", {rsp1_valid, rsp0_valid}, 2'b00);
    @(negedge clk);
    rst = 0;
    rsp0_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_vld", {rsp1_valid, rsp0_valid}, 2'b00);
    end
    run_op(0, 32'hFFFF_FFFF, 32'd1, 4'h0, 32'd0, 4'b0110, 1'b0);

    // Opcode 7: illegal when checking is built in
`ifdef ALU_ARB_OP_CHECK_EN
    run_op(1, 32'h1234, 32'h1, 4'h7, 32'd0, 4'b0000, 1'b1);
`else
    run_op(1, 32'h1234, 32'h1, 4'h7, 32'd0, 4'b0100, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, datapath width of operands and result.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester k presents an operation
- req0_ready / req1_ready  out  1  requester k operation accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  N  operands
- req0_op / req1_op  in  4  ALU select code
- rsp0_valid / rsp1_valid  out  1  response for requester k
- rsp0_ready / rsp1_ready  in  1  requester k takes response
- rsp_result  out  N  registered ALU result
- rsp_flags  out  4  {N,Z,C,V}
- rsp_err  out  1  illegal opcode (see Configuration)
- alu_a, alu_b  out  N  to shared ALU
- alu_s  out  4  to shared ALU select
- alu_z  in  N  ALU result
- alu_carry_out, alu_msb_sum  in  1  ALU status

Function
REQ-003 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-004 IDLE: reqk_ready SHALL equal grant k; only one ready high per cycle; both low outside IDLE.
REQ-005 Grant SHALL be round-robin: single valid wins; both valid -> requester not granted last.
REQ-006 On valid&&ready, operands, op and granted index SHALL be latched; next state EXEC.
REQ-007 EXEC: alu_a/alu_b/alu_s SHALL be driven from latched registers; at end of cycle rsp_result <= alu_z, flags captured; next state RESP.
REQ-008 Flags: N = alu_z[N-1]; Z = (alu_z == 0); C = alu_carry_out when op[3]==0 else 0; V = alu_msb_sum when op[3]==0 else 0.
REQ-009 RESP: rspk_valid SHALL be high only for latched index; held with result/flags stable until rspk_ready; on ready -> IDLE.
REQ-010 Latency: accept edge T; rsp valid from cycle T+2; minimum 3 cycles per operation.
REQ-011 Request arriving during EXEC/RESP SHALL wait (ready low); no loss, no reorder within requester.
REQ-012 alu_a/alu_b/alu_s SHALL hold last latched values outside EXEC (no glitching to zero).
REQ-013 Simultaneous rsp_ready and new req_valid in RESP: new request accepted no earlier than following IDLE cycle.

Reset
REQ-014 rst high SHALL immediately force: state IDLE, all ready/valid outputs 0, rsp_result 0, rsp_flags 0, rsp_err 0, alu_a/alu_b/alu_s 0, last-grant = requester 1 (so requester 0 wins first tie).
REQ-015 Reset mid-operation SHALL discard in-flight operation; no response issued.

Configuration
REQ-016 Macro ALU_ARB_OP_CHECK_EN defined: op in {2,3,6,7,15} SHALL skip ALU capture, give rsp_result 0, rsp_flags 0, rsp_err 1, same latency.
REQ-017 Macro undefined: rsp_err SHALL be constant 0; every op passed to ALU unchanged.

Structure
REQ-018 Shared package alu_pkg SHALL hold: alu_op_t 4-bit opcode typedef with legal encodings, flag index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), arbiter state enum.
REQ-019 Round-robin grant logic SHALL be sub-module rr_arbiter_2 (inputs two valids, last-grant; outputs one-hot grant).

Verification (bench instantiates shared ALU, N=32)
REQ-020 Single request: req0 a=5, b=3, op=4'h0 -> req0_ready same cycle, rsp0_valid at T+2, rsp_result=8, Z=0.
REQ-021 Tie after reset: both valid -> requester 0 served first, requester 1 next; repeated ties alternate 0,1,0,1.
REQ-022 Zero result: req1 a=7, b=7, op=4'h1 -> rsp_result=0, Z=1, rsp1_valid only.
REQ-023 Backpressure: rsp0_ready held low 5 cycles -> rsp0_valid, result, flags stable; req1_ready low throughout.
REQ-024 Reset in EXEC: rst pulsed -> no rsp valid; next request served normally with flags correct.
REQ-025 With ALU_ARB_OP_CHECK_EN: op=4'h7 -> rsp_err=1, rsp_result=0 at T+2; without macro rsp_err stays 0.
